// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample accumulator: widths, FSM state type
// and the averaging-exponent clamp.
package adc_pkg;

    localparam int ADC_DATA_W   = 10;
    localparam int ADC_MAX_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } acc_state_t;

    function automatic logic [2:0] clamp_log2(input logic [2:0] k, input logic [2:0] max_k);
        return (k > max_k) ? max_k : k;
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Show-ahead result FIFO: the head entry is presented on dout whenever the
// FIFO is non-empty, and reads zero while empty.
module adc_result_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    // A full FIFO still accepts a push when the same cycle frees an entry.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + LW'(1);
            else if (!do_push && do_pop)
                count <= count - LW'(1);
        end
    end

    // NOTE: storage has no reset; validity is tracked by count alone, so the
    // array can map onto plain RAM/register cells without a reset network.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/adc_sample_accumulator.sv
// Averages blocks of 2^K ADC conversions and queues each block average in a
// small show-ahead FIFO; a sticky flag reports results dropped on a full FIFO.
module adc_sample_accumulator
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int MAX_LOG2   = ADC_MAX_LOG2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] code_i,
    input  logic              eoc_i,
    input  logic              enable_i,
    input  logic [2:0]        avg_log2_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [2:0]        level_o,
    output logic              overflow_o
);

    localparam int SUM_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    acc_state_t        state;
    acc_state_t        state_next;
    logic              eoc_q;
    logic              sample_evt;
    logic              accept;
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        k_q;
    logic [SUM_W-1:0]  base_sum;
    logic [CNT_W-1:0]  base_cnt;
    logic [2:0]        blk_k;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              blk_done;
    logic              overflow_q;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] result;
    logic [LVL_W-1:0]  fifo_level;

    // Rising-edge detect: a level held high yields a single event.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            eoc_q <= 1'b0;
        else
            eoc_q <= eoc_i;
    end

    assign sample_evt = eoc_i & ~eoc_q & enable_i;
    assign accept     = sample_evt && (state != IDLE);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        base_sum = '0;
        base_cnt = '0;
        // During PUSH the registers still hold the finished block, so a new
        // sample starts the next block from zero.
        if (state == ACCUM) begin
            base_sum = sum_q;
            base_cnt = cnt_q;
        end
        blk_k    = (base_cnt == '0) ? clamp_log2(avg_log2_i, 3'(MAX_LOG2)) : k_q;
        sum_next = base_sum + SUM_W'(code_i);
        cnt_next = base_cnt + CNT_W'(1);
        blk_done = accept && (cnt_next == (CNT_W'(1) << blk_k));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:        state_next = ACCUM;
                ACCUM, PUSH: state_next = blk_done ? PUSH : ACCUM;
                default:     state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_push = (state == PUSH);
        result    = DATA_W'(sum_q >> k_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sum_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else if (!enable_i || state == IDLE) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            sum_q <= sum_next;
            cnt_q <= cnt_next;
            k_q   <= blk_k;
        end else if (state == PUSH) begin
            sum_q <= '0;
            cnt_q <= '0;
        end
    end

    assign fifo_pop = ~fifo_empty & ready_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            overflow_q <= 1'b0;
        else if (!enable_i)
            overflow_q <= 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop)
            overflow_q <= 1'b1;
    end

    adc_result_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (result),
        .dout  (data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign valid_o    = ~fifo_empty;
    assign level_o    = 3'(fifo_level);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_sample_accumulator.sv
// Directed bench for adc_sample_accumulator with a queue-based reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_adc_sample_accumulator;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [9:0] code_i;
    logic       eoc_i;
    logic       enable_i;
    logic [2:0] avg_log2_i;
    logic [9:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [2:0] level_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    adc_sample_accumulator dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .code_i     (code_i),
        .eoc_i      (eoc_i),
        .enable_i   (enable_i),
        .avg_log2_i (avg_log2_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: queue of completed averages and the samples of the
    // current block, updated once per clock edge from the bench's inputs.
    int exp_q[$];
    int blk[$];
    int blk_k;
    int pending;
    bit exp_ovf;
    bit eoc_prev;
    bit active;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        bit was_full, pop, drop, evt;
        int s;
        if (wb_rst_i) begin
            exp_q.delete();
            blk.delete();
            blk_k    = 0;
            pending  = -1;
            exp_ovf  = 0;
            eoc_prev = 0;
            active   = 0;
        end else begin
            was_full = (exp_q.size() == 4);
            pop      = (exp_q.size() > 0) && ready_i;
            drop     = 0;
            evt      = eoc_i && !eoc_prev && enable_i;
            if (pop)
                void'(exp_q.pop_front());
            if (pending >= 0) begin
                if (was_full && !pop)
                    drop = 1;
                else
                    exp_q.push_back(pending);
                pending = -1;
            end
            if (!enable_i) begin
                blk.delete();
                active  = 0;
                exp_ovf = 0;
            end else begin
                if (drop)
                    exp_ovf = 1;
                if (!active) begin
                    active = 1;
                end else if (evt) begin
                    if (blk.size() == 0)
                        blk_k = (avg_log2_i > 4) ? 4 : int'(avg_log2_i);
                    blk.push_back(int'(code_i));
                    if (blk.size() == (1 << blk_k)) begin
                        s = 0;
                        foreach (blk[i]) s += blk[i];
                        pending = s / (1 << blk_k);
                        blk.delete();
                    end
                end
            end
            eoc_prev = eoc_i;
        end
    end

    always @(negedge wb_clk_i) begin
        if (wb_rst_i === 1'b0) begin
            check("cmp_valid", valid_o, exp_q.size() > 0);
            check("cmp_level", level_o, exp_q.size());
            check("cmp_overflow", overflow_o, exp_ovf);
            check("cmp_data", data_o, (exp_q.size() > 0) ? exp_q[0] : 0);
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic conv(input logic [9:0] code);
        eoc_i  = 1'b1;
        code_i = code;
        tick();
        eoc_i  = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        ready_i = 1'b1;
        repeat (n) tick();
        ready_i = 1'b0;
    endtask

    initial begin
        code_i     = '0;
        eoc_i      = 1'b0;
        enable_i   = 1'b0;
        avg_log2_i = 3'd0;
        ready_i    = 1'b0;
        #12;
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_level", level_o, 0);
        check("rst_overflow", overflow_o, 0);
        tick();
        wb_rst_i = 1'b0;
        enable_i = 1'b1;
        tick();

        // K=0 pass-through with two-cycle latency.
        eoc_i  = 1'b1;
        code_i = 10'h3FF;
        tick();
        eoc_i  = 1'b0;
        check("k0_valid_early", valid_o, 0);
        tick();
        check("k0_valid_lat2", valid_o, 1);
        check("k0_data0", data_o, 10'h3FF);
        conv(10'h000);
        conv(10'h155);
        check("k0_level3", level_o, 3);
        check("k0_head", data_o, 10'h3FF);
        ready_i = 1'b1;
        tick();
        check("k0_pop1", data_o, 10'h000);
        tick();
        check("k0_pop2", data_o, 10'h155);
        tick();
        check("k0_empty", valid_o, 0);
        ready_i = 1'b0;

        // K=2: (10+11+12+14)/4 = 47>>2 = 11.
        avg_log2_i = 3'd2;
        conv(10'd10);
        conv(10'd11);
        conv(10'd12);
        conv(10'd14);
        check("k2_avg", data_o, 11);
        check("k2_level", level_o, 1);
        drain(1);

        // K=4 on 16 full-scale samples; a K change mid-block must not apply.
        avg_log2_i = 3'd4;
        for (int i = 0; i < 16; i++) begin
            conv(10'h3FF);
            if (i == 2)
                avg_log2_i = 3'd1;
            if (i == 14)
                check("k4_no_early_result", level_o, 0);
        end
        check("k4_level", level_o, 1);
        check("k4_avg", data_o, 10'h3FF);
        drain(1);

        // Fill the FIFO with ready low; the fifth and sixth results drop.
        avg_log2_i = 3'd0;
        for (int i = 1; i <= 6; i++)
            conv(10'(i));
        check("ovf_level", level_o, 4);
        check("ovf_head", data_o, 1);
        check("ovf_set", overflow_o, 1);
        enable_i = 1'b0;
        tick();
        check("ovf_cleared", overflow_o, 0);
        check("ovf_fifo_kept", level_o, 4);
        enable_i = 1'b1;
        tick();
        drain(4);
        check("ovf_drained", valid_o, 0);

        // Held eoc gives one sample.
        eoc_i  = 1'b1;
        code_i = 10'h2A;
        repeat (10) tick();
        eoc_i = 1'b0;
        tick();
        check("held_level", level_o, 1);
        check("held_data", data_o, 10'h2A);
        drain(1);

        // Abort a partial K=2 block; only the fresh four samples count.
        avg_log2_i = 3'd2;
        conv(10'd100);
        conv(10'd200);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        conv(10'd4);
        conv(10'd8);
        conv(10'd12);
        conv(10'd16);
        check("abort_level", level_o, 1);
        check("abort_avg", data_o, 10);

        // Fill and overflow, start a partial block, then reset mid-cycle.
        avg_log2_i = 3'd0;
        conv(10'd7);
        conv(10'd8);
        conv(10'd9);
        conv(10'd11);
        check("pre_rst_level", level_o, 4);
        check("pre_rst_ovf", overflow_o, 1);
        avg_log2_i = 3'd2;
        conv(10'd50);
        @(posedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("async_rst_data", data_o, 0);
        check("async_rst_valid", valid_o, 0);
        check("async_rst_level", level_o, 0);
        check("async_rst_ovf", overflow_o, 0);
        tick();
        wb_rst_i = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
